// File: rtl/button_debouncer.sv
// Per-channel push-button conditioner: 2-FF synchronizer followed by a
// stable-count debounce filter producing a clean level and press/release pulses.
module button_debouncer #(
  parameter int NUM_BUTTONS     = 3,
  parameter int CNT_WIDTH       = 20,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release
);

  localparam logic [CNT_WIDTH-1:0]   CNT_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_BUTTONS-1:0] IDLE_PIN = {NUM_BUTTONS{ACTIVE_LOW}};

  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
  logic [NUM_BUTTONS-1:0] level_q, level_d;
  logic [NUM_BUTTONS-1:0] press_q, press_d;
  logic [NUM_BUTTONS-1:0] release_q, release_d;
  logic [CNT_WIDTH-1:0]   cnt_q [NUM_BUTTONS];
  logic [CNT_WIDTH-1:0]   cnt_d [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] pressed;

  assign pressed = sync2_q ^ IDLE_PIN;

  // Any cycle of agreement clears the count, so only an unbroken run of
  // DEBOUNCE_CYCLES mismatches is accepted; the count never exceeds CNT_MAX.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (pressed[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i]   = pressed[i];
          press_d[i]   = pressed[i];
          release_d[i] = ~pressed[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= IDLE_PIN;
      sync2_q   <= IDLE_PIN;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios with hand-computed checks plus
// a history-based reference model feeding a per-cycle scoreboard.
module tb_button_debouncer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] btn_raw = 3'b111;
  logic [2:0] btn_level, btn_press, btn_release;

  int checks = 0;
  int failures = 0;

  button_debouncer #(
    .NUM_BUTTONS(3), .CNT_WIDTH(3), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a change is accepted when the last D synchronized
  // samples all disagree with the current level.
  logic [2:0]   m_s1 = 3'b111, m_s2 = 3'b111, m_lvl = '0, m_pr = '0, m_rl = '0;
  logic [D-1:0] hist [3];
  int           hcnt [3];
  logic         p;
  logic [8:0]   sb_q [$];

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = 3'b111; m_s2 = 3'b111; m_lvl = '0; m_pr = '0; m_rl = '0;
      for (int ch = 0; ch < 3; ch++) begin hist[ch] = '0; hcnt[ch] = 0; end
    end else begin
      m_pr = '0; m_rl = '0;
      for (int ch = 0; ch < 3; ch++) begin
        p = ~m_s2[ch];
        hist[ch] = {hist[ch][D-2:0], p};
        if (hcnt[ch] < D) hcnt[ch]++;
        if (hcnt[ch] == D && hist[ch] == {D{~m_lvl[ch]}}) begin
          m_lvl[ch] = p; m_pr[ch] = p; m_rl[ch] = ~p;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
    sb_q.push_back({m_lvl, m_pr, m_rl});
  end

  logic [2:0] prev_press = '0, prev_rel = '0;
  logic [8:0] exp_v;

  always @(posedge clk) begin
    #2;
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty actual=0 required=nonzero");
    end else begin
      exp_v = sb_q.pop_front();
      chk("scoreboard", {btn_level, btn_press, btn_release}, exp_v);
    end
    chk("press_release_overlap", {6'b0, btn_press & btn_release}, 9'b0);
    chk("pulse_width", {3'b0, btn_press & prev_press, btn_release & prev_rel}, 9'b0);
    prev_press = btn_press;
    prev_rel   = btn_rel_copy();
  end

  function automatic logic [2:0] btn_rel_copy();
    return btn_release;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [2:0] l, input logic [2:0] pr,
                            input logic [2:0] rl);
    chk(name, {btn_level, btn_press, btn_release}, {l, pr, rl});
  endtask

  initial begin
    // 1: reset held with idle pins, then idle
    repeat (3) begin tick(); expect_out("reset_hold", 3'b000, 3'b000, 3'b000); end
    reset = 1'b0;
    repeat (10) tick();
    expect_out("idle_after_reset", 3'b000, 3'b000, 3'b000);

    // 2: clean press on channel 0
    btn_raw = 3'b110;
    repeat (5) tick();
    expect_out("press0_before", 3'b000, 3'b000, 3'b000);
    tick();
    expect_out("press0_accept", 3'b001, 3'b001, 3'b000);
    tick();
    expect_out("press0_pulse_end", 3'b001, 3'b000, 3'b000);

    // 3: 3-cycle glitch on channel 1
    btn_raw = 3'b100;
    repeat (3) tick();
    btn_raw = 3'b110;
    repeat (8) begin tick(); expect_out("glitch1", 3'b001, 3'b000, 3'b000); end

    // 4: bounce on channel 2, final fall at i=8, then hold low
    for (int i = 0; i < 10; i++) begin
      btn_raw[2] = ((i / 2) % 2) != 0;
      tick();
    end
    repeat (3) tick();
    expect_out("bounce2_before", 3'b001, 3'b000, 3'b000);
    tick();
    expect_out("bounce2_press", 3'b101, 3'b100, 3'b000);
    tick();
    expect_out("bounce2_after", 3'b101, 3'b000, 3'b000);
    btn_raw[2] = 1'b1;
    repeat (5) tick();
    expect_out("release2_before", 3'b101, 3'b000, 3'b000);
    tick();
    expect_out("release2_accept", 3'b001, 3'b000, 3'b100);

    // 5: release ch0, then all pressed together, then reset while held
    btn_raw = 3'b111;
    repeat (6) tick();
    expect_out("release0", 3'b000, 3'b000, 3'b001);
    btn_raw = 3'b000;
    repeat (6) tick();
    expect_out("multi_press", 3'b111, 3'b111, 3'b000);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    expect_out("reset_while_held", 3'b000, 3'b000, 3'b000);
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    expect_out("held_through_reset_wait", 3'b000, 3'b000, 3'b000);
    tick();
    expect_out("held_through_reset_press", 3'b111, 3'b111, 3'b000);

    // 6: random bounce on all channels, checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      for (int ch = 0; ch < 3; ch++)
        if ($urandom_range(0, 2) == 0) btn_raw[ch] = ~btn_raw[ch];
      tick();
    end
    btn_raw = 3'b111;
    repeat (10) tick();
    expect_out("final_idle", 3'b000, 3'b000, 3'b000);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
